sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO and the next generation of the team's 8-deep sync FIFO. It supports any depth ≥2, including non-power-of-2, and keeps an explicit occupancy count. It adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a read-valid strobe. It sits between any producer/consumer pair in the same clock domain. Write and read may occur in the same cycle, including when the FIFO is full.

Parameters:
DATA_WIDTH, 32, width of each stored word
DEPTH, 8, number of entries; must be ≥2; power of 2 not required
AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH
AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1
CNT_W, $clog2(DEPTH+1), width of the count output (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request
rd_data  out  DATA_WIDTH  read word
rd_valid  out  1  rd_data holds a newly popped word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count ≥ AF_THRESH
almost_empty  out  1  count ≤ AE_THRESH
count  out  CNT_W  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was rejected
clr_err  in  1  clears overflow and underflow

Behaviour:
- Reset: synchronous, active-high, clock clk. Registered state: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Decoded flags after reset: empty=1, full=0, almost_full=0, almost_empty=1. Memory array is not reset.
- Reset mid-operation: all stored words are discarded. Any wr_en or rd_en in the reset cycle is ignored. The first legal access is in the cycle after rst deasserts.
- Pointers: range 0..DEPTH-1. On each accepted access the pointer increments; at DEPTH-1 it wraps to 0. Do not rely on power-of-2 truncation.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the registered count. They change in the cycle after the access that changes count. full and empty are never both 1.
- Write accept: wr_acc = wr_en && (!full || rd_en). When accepted, mem[wr_ptr] ← wr_data at the clock edge.
- Read accept: rd_acc = rd_en && !empty.
- Full + wr_en + rd_en: both are accepted, count stays DEPTH, and no overflow is flagged.
- Empty + wr_en + rd_en: the write is accepted, the read is rejected, underflow is set, and the next count is 1.
- Count update: count_next = count + wr_acc − rd_acc, always in the range 0..DEPTH.
- Read latency (baseline): rd_data ← mem[rd_ptr] at the edge where rd_acc=1, so the word is visible one cycle after rd_en. rd_valid=1 for exactly that cycle. rd_data holds its value otherwise.
- Overflow: set on wr_en && full && !rd_en. The write is dropped and no state other than the flag changes.
- Underflow: set on rd_en && empty. rd_data holds and rd_valid=0.
- Error clear: clr_err clears both sticky flags the next cycle. If clr_err and a new error event occur in the same cycle, the set wins.

Optional Feature:
FIFO_FWFT_EN
- Defined (first-word-fall-through): rd_data = mem[rd_ptr] combinationally whenever !empty, and is 0 when empty. rd_en acts as a pop/acknowledge. rd_valid = !empty, combinational. Read latency is 0. All other rules are unchanged, including the acceptance and error rules.
- Undefined: baseline registered read path described under Behaviour.

Test Plan:
1. Reset, then 8 writes of 0xA0..0xA7 (DEPTH=8) -> count=8, full=1, almost_full=1 from count 6 onward. Then 8 reads -> rd_data sequence 0xA0..0xA7 one cycle after each rd_en; empty=1 at the end.
2. Full FIFO, wr_en=1 and rd_en=0 with 0xFF -> overflow=1, count stays 8, and 0xFF is never read back. Then clr_err -> overflow=0 the next cycle.
3. Full FIFO, wr_en=1 and rd_en=1 with 0x55 for 1 cycle -> count=8, overflow=0, oldest word popped, and 0x55 is read last.
4. Empty FIFO, wr_en=1 and rd_en=1 with 0x33 -> underflow=1, count=1, rd_valid=0. Next rd_en -> rd_data=0x33.
5. DEPTH=6: 20 interleaved write/read pairs of incrementing data -> pointers wrap at 5→0, data order preserved, count never exceeds 6.
6. rst asserted with count=5 -> next cycle count=0, empty=1, overflow=0, underflow=0, rd_valid=0. With FIFO_FWFT_EN defined, a single write of 0x77 gives rd_data=0x77 and rd_valid=1 in the cycle after the write.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty,
// sticky overflow/underflow flags and a read-valid strobe. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [CNT_W-1:0]      count_next;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign wr_acc     = wr_en && (!full || rd_en);
    assign rd_acc     = rd_en && !empty;
    assign count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
        end
    end

    // Error flags are sticky; a new event in the clearing cycle wins over clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) overflow <= 1'b1;
            else if (clr_err)            overflow <= 1'b0;
            if (rd_en && empty)          underflow <= 1'b1;
            else if (clr_err)            underflow <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: an 8-deep instance for flag/error behaviour and a
// 6-deep instance for non-power-of-2 pointer wrap. Expectations follow FIFO_FWFT_EN if defined.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       wr_en6 = 1'b0, rd_en6 = 1'b0;
    logic [7:0] wr_data6 = '0;
    logic [7:0] rd_data6;
    logic       rd_valid6, full6, empty6, almost_full6, almost_empty6, overflow6, underflow6;
    logic [2:0] count6;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(6)) dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en6), .wr_data(wr_data6), .rd_en(rd_en6),
        .rd_data(rd_data6), .rd_valid(rd_valid6), .full(full6), .empty(empty6),
        .almost_full(almost_full6), .almost_empty(almost_empty6), .count(count6),
        .overflow(overflow6), .underflow(underflow6), .clr_err(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        wr_en6 = 1'b0; rd_en6 = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef FIFO_FWFT_EN
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        tick();
`else
        tick();
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
`endif
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst6_empty", 32'(empty6), 32'd1);

        // Fill with A0..A7 and watch the flags climb
        for (int i = 0; i < 8; i++) begin
            push(8'hA0 + 8'(i));
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_full", 32'(full), 32'(i + 1 == 8));
            check("fill_af", 32'(almost_full), 32'(i + 1 >= 6));
            check("fill_ae", 32'(almost_empty), 32'(i + 1 <= 1));
            check("fill_empty", 32'(empty), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            pop_check("drain", 8'hA0 + 8'(i));
            check("drain_count", 32'(count), 32'(7 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_full", 32'(full), 32'd0);

        // Overflow on full, dropped word, clear
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        tick();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) pop_check("ovf_drain", 8'hB0 + 8'(i));
        check("ovf_drain_empty", 32'(empty), 32'd1);

        // Simultaneous write and read while full
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        drive(1'b1, 8'h55, 1'b1, 1'b0);
`ifdef FIFO_FWFT_EN
        check("fullwr_data", 32'(rd_data), 32'hC0);
        tick();
`else
        tick();
        check("fullwr_data", 32'(rd_data), 32'hC0);
        check("fullwr_valid", 32'(rd_valid), 32'd1);
`endif
        check("fullwr_count", 32'(count), 32'd8);
        check("fullwr_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) pop_check("fullwr_drain", 8'hC0 + 8'(i));
        pop_check("fullwr_last", 8'h55);

        // Simultaneous write and read while empty
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        tick();
        check("emptywr_unf", 32'(underflow), 32'd1);
        check("emptywr_count", 32'(count), 32'd1);
`ifdef FIFO_FWFT_EN
        check("emptywr_valid", 32'(rd_valid), 32'd1);
`else
        check("emptywr_valid", 32'(rd_valid), 32'd0);
        check("emptywr_hold", 32'(rd_data), 32'h55);
`endif
        pop_check("emptywr_read", 8'h33);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        check("set_wins_unf", 32'(underflow), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("unf_clr", 32'(underflow), 32'd0);

        // Non-power-of-2 depth: prefill 3, 20 concurrent write/read cycles, drain
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en6 = 1'b1; wr_data6 = 8'(i);
            exp_q.push_back(8'(i));
            tick();
        end
        check("d6_prefill_count", 32'(count6), 32'd3);
        for (int i = 3; i < 23; i++) begin
            @(negedge clk);
            wr_en6 = 1'b1; wr_data6 = 8'(i); rd_en6 = 1'b1;
            exp_q.push_back(8'(i));
            exp_d = exp_q.pop_front();
`ifdef FIFO_FWFT_EN
            check("d6_pair_data", 32'(rd_data6), 32'(exp_d));
            tick();
`else
            tick();
            check("d6_pair_data", 32'(rd_data6), 32'(exp_d));
`endif
            check("d6_pair_count", 32'(count6), 32'd3);
        end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            rd_en6 = 1'b1;
            exp_d = exp_q.pop_front();
`ifdef FIFO_FWFT_EN
            check("d6_drain_data", 32'(rd_data6), 32'(exp_d));
            tick();
`else
            tick();
            check("d6_drain_data", 32'(rd_data6), 32'(exp_d));
`endif
        end
        check("d6_empty", 32'(empty6), 32'd1);
        check("d6_full", 32'(full6), 32'd0);

        // Reset mid-operation with pending errors and accesses in the reset cycle
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_unf", 32'(underflow), 32'd1);
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_unf", 32'(underflow), 32'd0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        push(8'h77);
`ifdef FIFO_FWFT_EN
        check("post_rst_data", 32'(rd_data), 32'h77);
        check("post_rst_valid", 32'(rd_valid), 32'd1);
`else
        check("post_rst_data", 32'(rd_data), 32'h00);
        check("post_rst_valid", 32'(rd_valid), 32'd0);
`endif
        check("post_rst_count", 32'(count), 32'd1);
        pop_check("post_rst_read", 8'h77);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
